// File: rtl/gpr_file_sb_pkg.sv
// Shared types for the GPR file with scoreboard.
package gpr_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int ADDR_W_DEF = 5;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/gpr_file_sb_if.sv
// Decode/writeback bundle between the pipeline and the GPR file.
interface gpr_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     init_done;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_addr;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     flush;

    modport master (
        output rd_addr, issue_en, issue_addr,
        output wb_en, wb_addr, wb_data, flush,
        input  init_done, rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, issue_en, issue_addr,
        input  wb_en, wb_addr, wb_data, flush,
        output init_done, rd_data, rd_busy
    );
endinterface

// File: rtl/gpr_file_sb_scoreboard.sv
// Per-register pending bits with issue > flush > writeback priority.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run_i,
    input  logic                     issue_en_i,
    input  logic [ADDR_W-1:0]        issue_addr_i,
    input  logic                     wb_en_i,
    input  logic [ADDR_W-1:0]        wb_addr_i,
    input  logic                     flush_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]        pend_o
);
    localparam int DEPTH = depth_of(ADDR_W);

    logic [DEPTH-1:0] pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        if (run_i) begin
            for (int a = 0; a < DEPTH; a++) begin
                if (issue_en_i && issue_addr_i == ADDR_W'(a))
                    pend_d[a] = 1'b1;
                else if (flush_i)
                    pend_d[a] = 1'b0;
                else if (wb_en_i && wb_addr_i == ADDR_W'(a))
                    pend_d[a] = 1'b0;
            end
            // Entry 0 is hardwired when it is the zero register.
            if (ZERO_REG != 0)
                pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pend_q <= '0;
        else
            pend_q <= pend_d;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_look
        assign pend_o[k] = pend_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/gpr_file_sb.sv
// GPR file: init sweep FSM, unreset storage, bypassed reads, scoreboard.
module gpr_file_sb
    import gpr_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         reset,
    gpr_file_sb_if.slave bus
);
    localparam int DEPTH = depth_of(ADDR_W);

    state_e             state_q;
    logic [ADDR_W-1:0]  cnt_q;
    logic               done_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               run;
    logic               wb_ok;
    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [DATA_W-1:0]  wdata;
    logic [NUM_RD-1:0]  pend;
    logic [NUM_RD-1:0]  busy;
    logic [NUM_RD*DATA_W-1:0] rdata;

    assign run   = (state_q == ST_RUN);
    assign wb_ok = run && bus.wb_en &&
                   (bus.wb_addr != '0 || ZERO_REG == 0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                        done_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_INIT;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // The sweep shares the single write port with writeback.
    assign we    = !run || wb_ok;
    assign waddr = run ? bus.wb_addr : cnt_q;
    assign wdata = run ? bus.wb_data : '0;

    always_ff @(posedge clk) begin
        if (we)
            mem_q[waddr] <= wdata;
    end

    gpr_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk          (clk),
        .reset        (reset),
        .run_i        (run),
        .issue_en_i   (bus.issue_en),
        .issue_addr_i (bus.issue_addr),
        .wb_en_i      (bus.wb_en),
        .wb_addr_i    (bus.wb_addr),
        .flush_i      (bus.flush),
        .rd_addr_i    (bus.rd_addr),
        .pend_o       (pend)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              zero_hit;
        logic              byp_hit;

        assign ra       = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign zero_hit = (ZERO_REG != 0) && (ra == '0);
        assign byp_hit  = (BYPASS != 0) && wb_ok &&
                          (bus.wb_addr == ra);

        assign rdata[k*DATA_W +: DATA_W] =
            !run     ? '0 :
            zero_hit ? '0 :
            byp_hit  ? bus.wb_data :
                       mem_q[ra];

        assign busy[k] = !run    ? 1'b1 :
                         byp_hit ? 1'b0 :
                                   pend[k];
    end

    assign bus.rd_data   = rdata;
    assign bus.rd_busy   = busy;
    assign bus.init_done = done_q;

endmodule

// File: tb/tb_gpr_file_sb.sv
// Directed bench for gpr_file_sb with a queue-based checker.
module tb_gpr_file_sb;

    typedef struct {
        string       nm;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t expq[$];

    gpr_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

    gpr_file_sb #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_RD   (2),
        .BYPASS   (1),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // kind: 0 = rd_data0, 1 = rd_data1, 2 = rd_busy, 3 = init_done
    always @(negedge clk) begin
        while (expq.size() > 0) begin
            exp_t        it;
            logic [31:0] act;
            it = expq.pop_front();
            case (it.kind)
                0:       act = bus.rd_data[31:0];
                1:       act = bus.rd_data[63:32];
                2:       act = {30'b0, bus.rd_busy};
                default: act = {31'b0, bus.init_done};
            endcase
            checks++;
            if (act !== it.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h",
                         it.nm, act, it.exp);
            end
        end
    end

    task automatic expect_v(input string nm, input int kind,
                            input logic [31:0] v);
        exp_t it;
        it.nm   = nm;
        it.kind = kind;
        it.exp  = v;
        expq.push_back(it);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.rd_addr = {a1, a0};
    endtask

    task automatic idle();
        bus.issue_en   = 1'b0;
        bus.issue_addr = '0;
        bus.wb_en      = 1'b0;
        bus.wb_addr    = '0;
        bus.wb_data    = '0;
        bus.flush      = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle();
        set_rd(5'd3, 5'd31);
        tick();
        reset = 1'b0;

        for (int c = 0; c < 32; c++) begin
            expect_v($sformatf("init_done_c%0d", c), 3, 32'd0);
            expect_v($sformatf("busy_init_c%0d", c), 2, 32'd3);
            expect_v($sformatf("data0_init_c%0d", c), 0, 32'd0);
            tick();
        end
        expect_v("init_done_run", 3, 32'd1);
        expect_v("rd3_zero", 0, 32'd0);
        expect_v("rd31_zero", 1, 32'd0);
        expect_v("busy_run", 2, 32'd0);

        tick();
        set_rd(5'd5, 5'd7);
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd5;
        bus.wb_data = 32'hDEADBEEF;
        expect_v("bypass_d0", 0, 32'hDEADBEEF);
        tick();
        idle();
        expect_v("stored_d0", 0, 32'hDEADBEEF);

        tick();
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd0;
        bus.wb_data = 32'h1234;
        tick();
        idle();
        set_rd(5'd0, 5'd7);
        expect_v("r0_read", 0, 32'd0);
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd0;
        tick();
        idle();
        expect_v("r0_busy", 2, 32'd0);

        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd7;
        tick();
        idle();
        expect_v("busy7_set", 2, 32'd2);
        tick();
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd7;
        bus.wb_data = 32'h55;
        expect_v("busy7_bypass", 2, 32'd0);
        expect_v("data7_bypass", 1, 32'h55);
        tick();
        idle();
        expect_v("busy7_clear", 2, 32'd0);
        expect_v("data7_stored", 1, 32'h55);

        set_rd(5'd9, 5'd7);
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd9;
        bus.wb_en      = 1'b1;
        bus.wb_addr    = 5'd9;
        bus.wb_data    = 32'h99;
        expect_v("iw9_bypass_busy", 2, 32'd0);
        expect_v("iw9_bypass_data", 0, 32'h99);
        tick();
        idle();
        expect_v("iw9_pending", 2, 32'd1);
        expect_v("iw9_data", 0, 32'h99);

        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd2;
        tick();
        bus.issue_addr = 5'd4;
        tick();
        bus.issue_addr = 5'd6;
        tick();
        set_rd(5'd2, 5'd6);
        idle();
        expect_v("pend_2_6", 2, 32'd3);
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd4;
        bus.flush      = 1'b1;
        tick();
        idle();
        set_rd(5'd2, 5'd4);
        expect_v("flush_2_4", 2, 32'd2);
        tick();
        set_rd(5'd6, 5'd9);
        expect_v("flush_6_9", 2, 32'd0);

        tick();
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd10;
        bus.wb_data = 32'hA5A5A5A5;
        tick();
        idle();
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd10;
        tick();
        idle();
        set_rd(5'd10, 5'd5);
        expect_v("r10_busy", 2, 32'd1);
        expect_v("r10_data", 0, 32'hA5A5A5A5);
        tick();
        reset = 1'b1;
        expect_v("rst_init_done", 3, 32'd0);
        expect_v("rst_busy", 2, 32'd3);
        expect_v("rst_data", 0, 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 32; c++)
            tick();
        expect_v("resweep_done", 3, 32'd1);
        expect_v("r10_cleared", 0, 32'd0);
        expect_v("r10_not_busy", 2, 32'd0);
        expect_v("r5_cleared", 1, 32'd0);

        @(negedge clk);
        #1;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expected 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
